// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request, ALU and response signal bundle for muldiv_seq
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_lhs;
    logic [XLEN-1:0] alu_rhs;
    logic [XLEN-1:0] alu_res;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    // Requester side, which also owns the shared ALU and the response consumer
    modport master (
        output req_valid, req_op, req_a, req_b, alu_res, resp_ready,
        input  req_ready, alu_op, alu_lhs, alu_rhs, resp_valid, resp_data
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_res, resp_ready,
        output req_ready, alu_op, alu_lhs, alu_rhs, resp_valid, resp_data
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative unsigned multiply/divide sequencer borrowing the core ALU
module muldiv_seq #(
    parameter int         XLEN   = 32,
    parameter int         ITERS  = 32,
    parameter logic [3:0] OP_ADD = 4'd0,
    parameter logic [3:0] OP_SUB = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam int               CNT_W    = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(ITERS - 1);
    localparam logic [1:0]       OP_MULHU = 2'd1;
    localparam logic [1:0]       OP_REMU  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_op;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;

    logic            w_last;
    logic            w_carry;
    logic            w_ge;
    logic [XLEN-1:0] w_rs;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_alu_lhs;
    logic [XLEN-1:0] w_alu_rhs;

    assign w_last = (r_count == LAST);

    // Multiply step: the ALU adds the partial product to hi; unsigned wrap reveals the carry,
    // and the 65-bit {carry, sum, lo} shifts right by one into {hi, lo}.
    assign w_carry  = (bus.alu_res < r_hi);
    assign w_hi_nxt = {w_carry, bus.alu_res[XLEN-1:1]};
    assign w_lo_nxt = {bus.alu_res[0], r_lo[XLEN-1:1]};

    // Restoring divide step: the shifted-out msb means the partial remainder already exceeds any divisor.
    assign w_rs      = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_ge      = r_rem[XLEN-1] | !(w_rs < r_dvsr);
    assign w_rem_nxt = w_ge ? bus.alu_res : w_rs;
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.alu_op     = w_alu_op;
    assign bus.alu_lhs    = w_alu_lhs;
    assign bus.alu_rhs    = w_alu_rhs;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and ALU operand drive; the ALU is driven only from registered state
    always_comb begin
        w_state_nxt = r_state;
        w_alu_op    = OP_ADD;
        w_alu_lhs   = '0;
        w_alu_rhs   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = bus.req_op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                w_alu_op  = OP_ADD;
                w_alu_lhs = r_hi;
                w_alu_rhs = r_lo[0] ? r_mcand : '0;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                w_alu_op  = OP_SUB;
                w_alu_lhs = w_rs;
                w_alu_rhs = r_dvsr;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and response register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op         <= '0;
            r_count      <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_mcand      <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvsr       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_count <= '0;
                        if (bus.req_op[1]) begin
                            r_rem  <= '0;
                            r_quo  <= bus.req_a;
                            r_dvsr <= bus.req_b;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= bus.req_a;
                            r_mcand <= bus.req_b;
                        end
                    end
                end
                S_MUL: begin
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= (r_op == OP_MULHU) ? w_hi_nxt : w_lo_nxt;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_rem_nxt;
                    r_quo   <= w_quo_nxt;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= (r_op == OP_REMU) ? w_rem_nxt : w_quo_nxt;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_resp_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int          m_phase = 0;
    int          m_left  = 0;
    bit          m_div   = 0;
    logic [31:0] m_exp   = '0;
    int          m_resps = 0;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(
        .XLEN  (32),
        .ITERS (32),
        .OP_ADD(OP_ADD),
        .OP_SUB(OP_SUB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Shared ALU owned by the execute stage
    always_comb begin
        bus.alu_res = (bus.alu_op == OP_SUB) ? (bus.alu_lhs - bus.alu_rhs)
                                             : (bus.alu_lhs + bus.alu_rhs);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle-level model: idle -> 32 busy cycles -> done until consumed
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_phase = 0;
                m_left  = 0;
            end else begin
                chk("req_ready", 32'(bus.req_ready), 32'(m_phase == 0));
                chk("resp_valid", 32'(bus.resp_valid), 32'(m_phase == 2));
                if (m_phase == 2) chk("resp_data_model", bus.resp_data, m_exp);
                if (m_phase == 1) chk("alu_op_busy", 32'(bus.alu_op), 32'(m_div ? OP_SUB : OP_ADD));
                if (m_phase == 0) begin
                    if (bus.req_valid) begin
                        m_phase = 1;
                        m_left  = 32;
                        m_div   = bus.req_op[1];
                        m_exp   = ref_result(bus.req_op, bus.req_a, bus.req_b);
                    end
                end else if (m_phase == 1) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end else if (bus.resp_ready) begin
                    m_phase = 0;
                    m_resps++;
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold, input string name);
        int n;
        bit ok;
        logic [31:0] held;
        @(posedge clk); #1;
        bus.resp_ready = (hold == 0);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
        end
        chk({name, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_op    = 2'($urandom);
        n  = 0;
        ok = 0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid) ok = 1;
        end
        chk({name, "_latency"}, 32'(n), 32'd33);
        chk({name, "_data"}, bus.resp_data, exp);
        if (hold > 0) begin
            held = bus.resp_data;
            @(posedge clk); #1;
            bus.req_valid = 1'b1;
            bus.req_op    = 2'd0;
            bus.req_a     = 32'd9;
            bus.req_b     = 32'd9;
            for (int k = 1; k < hold; k++) begin
                @(negedge clk);
                chk({name, "_hold_data"}, bus.resp_data, held);
                chk({name, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
            end
            @(posedge clk); #1;
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
            @(negedge clk);
            chk({name, "_hs_valid"}, 32'(bus.resp_valid), 32'd1);
            @(negedge clk);
            chk({name, "_post_req_ready"}, 32'(bus.req_ready), 32'd1);
            chk({name, "_post_valid"}, 32'(bus.resp_valid), 32'd0);
            chk({name, "_post_data"}, bus.resp_data, held);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit ok;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        chk("rst_alu_lhs", bus.alu_lhs, 32'd0);
        chk("rst_alu_rhs", bus.alu_rhs, 32'd0);
        reset = 1'b0;

        run_op(2'd0, 32'd7,          32'd6,          32'h0000_002A, 0, "mul_7x6");
        run_op(2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 0, "mul_ffxff");
        run_op(2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 0, "mulhu_ffxff");
        run_op(2'd2, 32'd100,        32'd7,          32'h0000_000E, 0, "divu_100_7");
        run_op(2'd3, 32'd100,        32'd7,          32'h0000_0002, 0, "remu_100_7");
        run_op(2'd2, 32'h8000_0000,  32'd1,          32'h8000_0000, 0, "divu_msb_1");
        run_op(2'd2, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 0, "divu_by0");
        run_op(2'd3, 32'h0000_1234,  32'd0,          32'h0000_1234, 0, "remu_by0");
        run_op(2'd2, 32'd5,          32'd9,          32'h0000_0000, 0, "divu_small");
        run_op(2'd0, 32'h0001_0000,  32'h0000_0010,  32'h0010_0000, 5, "mul_backpressure");

        // Abort an in-flight divide with reset
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd2;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd3;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
        end
        chk("abort_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);

        run_op(2'd0, 32'd3, 32'd5, 32'h0000_000F, 0, "mul_3x5_after_rst");

        repeat (3) @(negedge clk);
        chk("resp_count", 32'(m_resps), 32'd11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
